// File: rtl/iopad_pkg.sv
// Shared configuration layout for the iopad bank: per-pad config bit positions
// and the power-on pad configuration.
package iopad_pkg;
  localparam int CFG_BITS_PER_PAD = 2;
  localparam int DIR_BIT          = 0;
  localparam int RM_BIT           = 1;

  typedef struct packed {
    logic rm;   // registered mode
    logic dir;  // 1 = input
  } pad_cfg_t;

  // Safe default: input, combinational, so nothing is driven out of reset.
  localparam pad_cfg_t PAD_CFG_RST = '{rm: 1'b0, dir: 1'b1};
endpackage

// File: rtl/iopad_cell.sv
// One bidirectional pad: output enable, registered/combinational muxing in
// both directions, and the dout/pad sampling flops.
module iopad_cell
  import iopad_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic i_dir,
  input  logic i_rm,
  input  logic i_hiz,
  input  logic i_dout,
  output logic o_din,
  output logic o_oe,
  inout  wire  io_pad
);
  logic r_dout_q;
  logic r_pad_q;
  logic w_oe;
  logic w_drv;

  // Both sample flops run every cycle so a mode switch never sees stale data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_dout_q <= 1'b0;
      r_pad_q  <= 1'b0;
    end else begin
      r_dout_q <= i_dout;
      r_pad_q  <= io_pad;
    end
  end

  assign w_oe   = ~i_dir & ~i_hiz;
  assign w_drv  = i_rm ? r_dout_q : i_dout;
  assign io_pad = w_oe ? w_drv : 1'bz;
  assign o_din  = i_dir ? (i_rm ? r_pad_q : io_pad) : 1'b0;
  assign o_oe   = w_oe;
endmodule

// File: rtl/iopad_bank.sv
// Bank of NUM_PADS bidirectional pads configured through a chainable serial
// shift register; a frame is committed only when exactly complete.
module iopad_bank
  import iopad_pkg::*;
#(
  parameter int NUM_PADS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                zin,
  input  logic                cfg_en,
  input  logic                cfg_in,
  input  logic                cfg_update,
  output logic                cfg_out,
  output logic                cfg_ok,
  input  logic [NUM_PADS-1:0] dout,
  output logic [NUM_PADS-1:0] din,
  inout  wire  [NUM_PADS-1:0] pad
);
  localparam int SH_W  = CFG_BITS_PER_PAD * NUM_PADS;
  localparam int CNT_W = $clog2(SH_W + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SH_W);
  localparam logic [SH_W-1:0]  ACT_RST  = {NUM_PADS{PAD_CFG_RST}};

  logic [SH_W-1:0]     r_sh;
  logic [SH_W-1:0]     r_active;
  logic [CNT_W-1:0]    r_cnt;
  logic                r_ok;
  logic                w_commit;
  logic                w_full;
  logic                w_hiz;
  logic [NUM_PADS-1:0] w_oe;

  // Shifting wins over an update arriving in the same cycle.
  assign w_commit = cfg_update & ~cfg_en;
  assign w_full   = (r_cnt == CNT_FULL);
  assign w_hiz    = zin | cfg_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sh  <= '0;
      r_cnt <= '0;
      r_ok  <= 1'b0;
    end else if (cfg_en) begin
      r_sh <= {r_sh[SH_W-2:0], cfg_in};
      if (!w_full) r_cnt <= r_cnt + 1'b1;
      r_ok <= 1'b0;
    end else if (w_commit) begin
      r_cnt <= '0;
      r_ok  <= w_full;
    end
  end

  // Partial frames leave the live configuration untouched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                   r_active <= ACT_RST;
    else if (w_commit && w_full) r_active <= r_sh;
  end

  assign cfg_out = r_sh[SH_W-1];
  assign cfg_ok  = r_ok;

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_pad
    iopad_cell u_cell (
      .clk    (clk),
      .rst    (rst),
      .i_dir  (r_active[CFG_BITS_PER_PAD*g + DIR_BIT]),
      .i_rm   (r_active[CFG_BITS_PER_PAD*g + RM_BIT]),
      .i_hiz  (w_hiz),
      .i_dout (dout[g]),
      .o_din  (din[g]),
      .o_oe   (w_oe[g]),
      .io_pad (pad[g])
    );
  end
endmodule

// File: tb/tb_iopad_bank.sv
module tb_iopad_bank;
  localparam int N = 4;

  logic         clk, rst, zin, cfg_en, cfg_in, cfg_update;
  logic         cfg_out, cfg_ok;
  logic [N-1:0] dout, din;
  wire  [N-1:0] pad;
  logic [N-1:0] tb_oe, tb_val;
  wire  [N-1:0] w_oe_obs;

  for (genvar g = 0; g < N; g++) begin : g_drv
    assign pad[g] = tb_oe[g] ? tb_val[g] : 1'bz;
  end

  iopad_bank #(.NUM_PADS(N)) dut (
    .clk(clk), .rst(rst), .zin(zin), .cfg_en(cfg_en), .cfg_in(cfg_in),
    .cfg_update(cfg_update), .cfg_out(cfg_out), .cfg_ok(cfg_ok),
    .dout(dout), .din(din), .pad(pad)
  );

  assign w_oe_obs = dut.w_oe;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]   m;
    logic [N-1:0] oe;
    logic [N-1:0] pv;
    logic [N-1:0] dn;
    logic         ok;
    logic         co;
  } exp_t;

  localparam logic [4:0] M_ALL = 5'b11111;
  localparam logic [4:0] M_NCO = 5'b01111;

  exp_t  q_exp[$];
  string q_nm[$];
  int    n_vec = 0;
  int    n_bad = 0;

  task automatic chk(input string nm, input logic cond);
    n_vec++;
    if (cond !== 1'b1) begin
      n_bad++;
      $display("FAIL %s: oe=%b pad=%b din=%b ok=%b cfg_out=%b",
               nm, w_oe_obs, pad, din, cfg_ok, cfg_out);
    end
  endtask

  task automatic push(input string nm, input logic [4:0] m, input logic [N-1:0] oe,
                      input logic [N-1:0] pv, input logic [N-1:0] dn, input logic ok,
                      input logic co);
    exp_t e;
    e = '{m: m, oe: oe, pv: pv, dn: dn, ok: ok, co: co};
    q_exp.push_back(e);
    q_nm.push_back(nm);
  endtask

  exp_t  mon_e;
  string mon_nm;
  logic  mon_bad;

  always @(negedge clk) begin
    while (q_exp.size() > 0) begin
      mon_e  = q_exp.pop_front();
      mon_nm = q_nm.pop_front();
      mon_bad = 1'b0;
      if (mon_e.m[0] && (w_oe_obs !== mon_e.oe)) mon_bad = 1'b1;
      if (mon_e.m[1] && ((pad & mon_e.oe) !== (mon_e.pv & mon_e.oe))) mon_bad = 1'b1;
      if (mon_e.m[2] && (din !== mon_e.dn)) mon_bad = 1'b1;
      if (mon_e.m[3] && (cfg_ok !== mon_e.ok)) mon_bad = 1'b1;
      if (mon_e.m[4] && (cfg_out !== mon_e.co)) mon_bad = 1'b1;
      n_vec++;
      if (mon_bad) begin
        n_bad++;
        $display("FAIL %s: got oe=%b pad=%b din=%b ok=%b cfg_out=%b, need oe=%b pad=%b din=%b ok=%b cfg_out=%b (mask %b)",
                 mon_nm, w_oe_obs, pad, din, cfg_ok, cfg_out,
                 mon_e.oe, mon_e.pv & mon_e.oe, mon_e.dn, mon_e.ok, mon_e.co, mon_e.m);
      end
    end
  end

  initial begin
    #100000;
    chk("timeout", 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      cfg_en = 1'b1;
      cfg_in = bits[i];
      tick();
    end
    cfg_en = 1'b0;
  endtask

  task automatic do_update(input logic z);
    zin        = z;
    cfg_update = 1'b1;
    tick();
    cfg_update = 1'b0;
  endtask

  logic [15:0] chain_bits;

  initial begin
    rst = 1'b1; zin = 1'b0; cfg_en = 1'b0; cfg_in = 1'b0; cfg_update = 1'b0;
    dout = '0; tb_oe = 4'b1111; tb_val = 4'b1010;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    chk("reset_state", (w_oe_obs === 4'b0000) && (cfg_ok === 1'b0) && (din === 4'b1010));

    push("reset", M_ALL, 4'b0000, 4'b0000, 4'b1010, 1'b0, 1'b0); tick();
    tb_val = 4'b0101;
    push("din_comb", M_ALL, 4'b0000, 4'b0000, 4'b0101, 1'b0, 1'b0); tick();

    shift(16'h0002, 8);
    tb_oe = 4'b0000;
    do_update(1'b0);
    push("commit", M_ALL, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0); tick();
    dout = 4'b0001;
    push("reg_lat0", M_ALL, 4'b1111, 4'b0000, 4'b0000, 1'b1, 1'b0); tick();
    push("reg_lat1", M_ALL, 4'b1111, 4'b0001, 4'b0000, 1'b1, 1'b0); tick();
    dout = 4'b1110;
    push("comb_imm", M_ALL, 4'b1111, 4'b1111, 4'b0000, 1'b1, 1'b0); tick();
    push("reg_settle", M_ALL, 4'b1111, 4'b1110, 4'b0000, 1'b1, 1'b0); tick();

    zin = 1'b1;
    push("zin_hi", M_ALL, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0); tick();
    zin = 1'b0;
    push("zin_lo", M_ALL, 4'b1111, 4'b1110, 4'b0000, 1'b1, 1'b0); tick();
    cfg_en = 1'b1; cfg_in = 1'b0;
    push("cfgen_z", M_NCO, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0); tick();
    cfg_en = 1'b0;
    push("ok_clear", M_NCO, 4'b1111, 4'b1110, 4'b0000, 1'b0, 1'b0); tick();

    shift(16'h0015, 5);
    do_update(1'b0);
    push("partial", M_NCO, 4'b1111, 4'b1110, 4'b0000, 1'b0, 1'b0); tick();

    chain_bits = 16'hA5C3;
    cfg_en = 1'b1;
    tb_oe = 4'b1001; tb_val = 4'b1001; dout = 4'b0100;
    for (int i = 0; i < 16; i++) begin
      cfg_en = 1'b1;
      cfg_in = chain_bits[15 - i];
      if (i >= 8) push("chain", 5'b10001, 4'b0000, 4'b0000, 4'b0000, 1'b0, chain_bits[23 - i]);
      tick();
    end
    cfg_en = 1'b0;
    do_update(1'b1);
    zin = 1'b0;
    push("chain_commit", M_ALL, 4'b0110, 4'b0100, 4'b1001, 1'b1, 1'b1); tick();
    tb_val = 4'b0001;
    push("rm_in_lat0", M_ALL, 4'b0110, 4'b0100, 4'b1001, 1'b1, 1'b1); tick();
    push("rm_in_lat1", M_ALL, 4'b0110, 4'b0100, 4'b0001, 1'b1, 1'b1); tick();

    zin = 1'b1; tb_oe = 4'b1111; tb_val = 4'b0110;
    shift(16'h000F, 4);
    rst = 1'b1;
    #2 rst = 1'b0;
    push("rst_mid", M_ALL, 4'b0000, 4'b0000, 4'b0110, 1'b0, 1'b0); tick();
    shift(16'h0005, 4);
    do_update(1'b1);
    push("rst_nofr", M_ALL, 4'b0000, 4'b0000, 4'b0110, 1'b0, 1'b0); tick();
    dout = 4'b0001; tb_oe = 4'b1110;
    shift(16'h0056, 8);
    do_update(1'b1);
    zin = 1'b0;
    push("fresh", M_ALL, 4'b0001, 4'b0001, 4'b0110, 1'b1, 1'b0); tick();

    tick();
    chk("queue_drained", q_exp.size() == 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule

// File: doc/iopad_bank.md
IOPAD_BANK -- requirements
Module: iopad_bank

Interface
REQ-001 Parameter NUM_PADS, default 8, SHALL set the number of bidirectional pads (legal range 1..64).
REQ-002 Constant CFG_BITS_PER_PAD, value 2, SHALL set configuration bits per pad (bit 0 = direction, bit 1 = registered mode).
REQ-003 Port clk  input  1  SHALL be the single clock; all flops use its rising edge.
REQ-004 Port rst  input  1  SHALL be the reset: asynchronous, active-high.
REQ-005 Port zin  input  1  SHALL force every pad to Z when high.
REQ-006 Port cfg_en  input  1  SHALL enable serial configuration shifting when high.
REQ-007 Port cfg_in  input  1  SHALL be the serial configuration data in.
REQ-008 Port cfg_update  input  1  SHALL be a one-cycle pulse that commits shifted configuration.
REQ-009 Port cfg_out  output  1  SHALL be the serial configuration data out, for chaining banks.
REQ-010 Port cfg_ok  output  1  SHALL indicate that the last commit loaded a complete frame.
REQ-011 Port dout  input  NUM_PADS  SHALL be the fabric-to-pad data.
REQ-012 Port din  output  NUM_PADS  SHALL be the pad-to-fabric data.
REQ-013 Port pad  inout  NUM_PADS  SHALL be the bidirectional pads.

Function
REQ-014 Shift register sh (2*NUM_PADS bits) SHALL shift on each clk with cfg_en=1: sh <= {sh[2N-2:0], cfg_in}.
REQ-015 cfg_out SHALL equal sh[2N-1] combinationally.
REQ-016 Bit-count register SHALL increment once per shift cycle and saturate at 2N; its width SHALL be clog2(2N+1).
REQ-017 cfg_ok SHALL clear on the first clk with cfg_en=1.
REQ-018 On cfg_update=1 with cfg_en=0: if count==2N, active config <= sh and cfg_ok <= 1; otherwise active config is unchanged and cfg_ok <= 0. Count <= 0 in both cases.
REQ-019 cfg_update with cfg_en=1 SHALL be ignored; shifting takes precedence.
REQ-020 Pad i uses dir = active[2i] and rm = active[2i+1]; dir=1 means input.
REQ-021 Pad i SHALL be driven only when dir=0, zin=0 and cfg_en=0; otherwise it SHALL be Z.
REQ-022 Driven value SHALL be dout_q[i] (dout registered, 1-cycle latency) when rm=1, and dout[i] combinationally when rm=0.
REQ-023 When dir=1, din[i] SHALL be pad_q[i] (pad sampled, 1-cycle latency) when rm=1, and pad[i] combinationally when rm=0.
REQ-024 When dir=0, din[i] SHALL be 0; din SHALL never be Z.
REQ-025 dout_q and pad_q SHALL update every clk regardless of mode.
REQ-026 Reconfiguration SHALL take effect on the clk edge after the cfg_update edge; no glitch to a driven state while cfg_en=1.

Reset
REQ-027 rst SHALL asynchronously clear sh, count, dout_q, pad_q and cfg_ok to 0.
REQ-028 rst SHALL set the active config to all dir=1, rm=0, so all pads are Z and din follows pad.
REQ-029 rst asserted during shifting SHALL abort the frame; a commit after reset without a full new frame SHALL leave cfg_ok=0.

Structure
REQ-030 Package iopad_pkg SHALL hold CFG_BITS_PER_PAD, DIR_BIT=0 and RM_BIT=1.
REQ-031 Per-pad logic (tristate, mux, dout_q/pad_q) SHALL be sub-module iopad_cell, instantiated NUM_PADS times; the shift, count and commit logic stays in iopad_bank.

Verification
REQ-032 Reset, NUM_PADS=4: after rst, pad=ZZZZ, cfg_ok=0; external pad=4'b1010 gives din=4'b1010 in the same cycle.
REQ-033 Shift 0,0,0,0,0,0,1,0 (8 clks), then pulse cfg_update -> cfg_ok=1, all pads output, pad0 registered; dout=4'b0001 gives pad[0]=1 one clk later and pad[3:1]=000 immediately.
REQ-034 Shift only 5 bits, then update -> cfg_ok=0 and previous pad config unchanged.
REQ-035 Configured as outputs, zin=1 -> pad=ZZZZ; zin=0 -> drive resumes in the same cycle; cfg_en=1 also forces ZZZZ.
REQ-036 Chain check: shift 16 bits 0xA5C3 into N=4 -> cfg_out replays the first 8 bits (0xA5) during clks 9-16.
REQ-037 rst pulsed after 4 of 8 shift bits, then 8 fresh bits and update -> cfg_ok=1 with only the fresh frame applied.
